// File: rtl/fetch_issue_queue_if.sv
// rtl/fetch_issue_queue_if.sv - fetch-side push and issue-side pop signals of the fetch/issue queue
interface fetch_issue_queue_if #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            flush;
  logic            stall;
  logic [1:0]      in_valid;
  logic [31:0]     in_inst0;
  logic [31:0]     in_inst1;
  logic [PC_W-1:0] in_pc;
  logic            in_ready;
  logic [1:0]      out_valid;
  logic [31:0]     out_inst0;
  logic [31:0]     out_inst1;
  logic [PC_W-1:0] out_pc0;
  logic [PC_W-1:0] out_pc1;
  logic [CW-1:0]   count;

  modport master (
    output flush, stall, in_valid, in_inst0, in_inst1, in_pc,
    input  in_ready, out_valid, out_inst0, out_inst1, out_pc0, out_pc1, count
  );

  modport slave (
    input  flush, stall, in_valid, in_inst0, in_inst1, in_pc,
    output in_ready, out_valid, out_inst0, out_inst1, out_pc0, out_pc1, count
  );
endinterface

// File: rtl/fetch_issue_queue.sv
// rtl/fetch_issue_queue.sv - dual-wide fetch/issue circular queue with slot1 pairing hazard checks
module fetch_issue_queue #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  fetch_issue_queue_if.slave  fif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic [31:0]     inst_mem [DEPTH];
  logic [PC_W-1:0] pc_mem   [DEPTH];

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] cnt;

  logic [AW-1:0] head_nxt1;
  logic [AW-1:0] tail_nxt1;
  logic          push0;
  logic          push1;
  logic [1:0]    push_n;
  logic [1:0]    pop_n;
  logic [31:0]   slot0_inst;
  logic [31:0]   slot1_inst;
  logic          has_one;
  logic          has_two;
  logic          hazard;

  function automatic logic writes_rd(input logic [6:0] op);
    case (op)
      OP_OP, OP_IMM, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: writes_rd = 1'b1;
      default:                                                  writes_rd = 1'b0;
    endcase
  endfunction

  function automatic logic reads_rs1(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL: reads_rs1 = 1'b0;
      default:                  reads_rs1 = 1'b1;
    endcase
  endfunction

  function automatic logic reads_rs2(input logic [6:0] op);
    case (op)
      OP_OP, OP_STORE, OP_BRANCH: reads_rs2 = 1'b1;
      default:                    reads_rs2 = 1'b0;
    endcase
  endfunction

  function automatic logic is_ctrl(input logic [6:0] op);
    case (op)
      OP_BRANCH, OP_JAL, OP_JALR: is_ctrl = 1'b1;
      default:                    is_ctrl = 1'b0;
    endcase
  endfunction

  function automatic logic is_mem(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_STORE: is_mem = 1'b1;
      default:           is_mem = 1'b0;
    endcase
  endfunction

  assign head_nxt1 = head + 1'b1;
  assign tail_nxt1 = tail + 1'b1;

  // Acceptance looks only at registered occupancy, so a same-cycle pop never earns credit.
  always_comb begin
    fif.in_ready = (cnt <= CW'(DEPTH - 2));
    push0        = fif.in_ready & ~fif.flush & fif.in_valid[0];
    push1        = push0 & fif.in_valid[1];
    push_n       = {1'b0, push0} + {1'b0, push1};
  end

  always_comb begin
    has_one    = (cnt >= CW'(1));
    has_two    = (cnt >= CW'(2));
    slot0_inst = inst_mem[head];
    slot1_inst = inst_mem[head_nxt1];

    fif.out_inst0 = has_one ? slot0_inst       : '0;
    fif.out_pc0   = has_one ? pc_mem[head]      : '0;
    fif.out_inst1 = has_two ? slot1_inst       : '0;
    fif.out_pc1   = has_two ? pc_mem[head_nxt1] : '0;
  end

  // Slot1 is withheld when it depends on slot0, follows a redirect, or would double up on the LSU.
  always_comb begin
    hazard = 1'b0;
    if (writes_rd(slot0_inst[6:0]) && (slot0_inst[11:7] != 5'd0)) begin
      if (reads_rs1(slot1_inst[6:0]) && (slot1_inst[19:15] == slot0_inst[11:7]))
        hazard = 1'b1;
      if (reads_rs2(slot1_inst[6:0]) && (slot1_inst[24:20] == slot0_inst[11:7]))
        hazard = 1'b1;
    end
    if (is_ctrl(slot0_inst[6:0]))
      hazard = 1'b1;
    if (is_mem(slot0_inst[6:0]) && is_mem(slot1_inst[6:0]))
      hazard = 1'b1;
  end

  always_comb begin
    fif.out_valid    = 2'b00;
    fif.out_valid[0] = has_one & ~fif.stall & ~fif.flush;
    fif.out_valid[1] = fif.out_valid[0] & has_two & ~hazard;
    pop_n            = {1'b0, fif.out_valid[0]} + {1'b0, fif.out_valid[1]};
  end

  assign fif.count = cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (fif.flush) begin
      head <= tail;
      cnt  <= '0;
    end else begin
      head <= head + AW'(pop_n);
      tail <= tail + AW'(push_n);
      cnt  <= cnt + CW'(push_n) - CW'(pop_n);
    end
  end

  // Entry storage needs no reset: nothing is visible beyond the registered count.
  always_ff @(posedge clk) begin
    if (push0) begin
      inst_mem[tail] <= fif.in_inst0;
      pc_mem[tail]   <= fif.in_pc;
    end
    if (push1) begin
      inst_mem[tail_nxt1] <= fif.in_inst1;
      pc_mem[tail_nxt1]   <= fif.in_pc + PC_W'(4);
    end
  end
endmodule

// File: tb/tb_fetch_issue_queue.sv
// tb/tb_fetch_issue_queue.sv - self-checking bench for fetch_issue_queue against a queue-based model
module tb_fetch_issue_queue;
  localparam int DEPTH = 8;
  localparam int PC_W  = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_issue_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W)) fif ();
  fetch_issue_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (.clk(clk), .reset(reset), .fif(fif));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0]     inst;
    logic [PC_W-1:0] pc;
  } ent_t;
  ent_t q[$];

  logic            c_fl, c_st;
  logic [1:0]      c_iv;
  logic [31:0]     c_i0, c_i1;
  logic [PC_W-1:0] c_pc;
  logic [1:0]      e_valid;
  logic            e_ready;
  logic [CW-1:0]   e_count;

  // Pairing rules written straight from the opcode lists of the ISA subset.
  function automatic bit pair_blocked(input logic [31:0] a, input logic [31:0] b);
    logic [6:0] opa, opb;
    bit a_wr, b_rs1, b_rs2;
    opa   = a[6:0];
    opb   = b[6:0];
    a_wr  = opa inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1101111,
                        7'b1100111, 7'b0110111, 7'b0010111};
    b_rs1 = !(opb inside {7'b0110111, 7'b0010111, 7'b1101111});
    b_rs2 = opb inside {7'b0110011, 7'b0100011, 7'b1100011};
    if (a_wr && a[11:7] != 5'd0 &&
        ((b_rs1 && b[19:15] == a[11:7]) || (b_rs2 && b[24:20] == a[11:7])))
      return 1'b1;
    if (opa inside {7'b1100011, 7'b1101111, 7'b1100111})
      return 1'b1;
    if ((opa inside {7'b0000011, 7'b0100011}) && (opb inside {7'b0000011, 7'b0100011}))
      return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] mk_addi(input int k);
    logic [11:0] imm;
    imm = 12'(k);
    return {imm, 5'd0, 3'b000, 5'd5, 7'b0010011};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [9];
    logic [31:0] r;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    r        = $urandom;
    r[6:0]   = ops[$urandom_range(0, 8)];
    r[11:7]  = 5'($urandom_range(0, 3));
    r[19:15] = 5'($urandom_range(0, 3));
    r[24:20] = 5'($urandom_range(0, 3));
    return r;
  endfunction

  // Drive one cycle of inputs (called just after a rising edge) and derive expectations.
  task automatic apply(input logic fl, input logic st, input logic [1:0] iv,
                       input logic [31:0] i0, input logic [31:0] i1, input logic [PC_W-1:0] pc);
    fif.flush = fl; fif.stall = st; fif.in_valid = iv;
    fif.in_inst0 = i0; fif.in_inst1 = i1; fif.in_pc = pc;
    c_fl = fl; c_st = st; c_iv = iv; c_i0 = i0; c_i1 = i1; c_pc = pc;
    e_count = CW'(q.size());
    e_ready = (q.size() <= DEPTH - 2);
    e_valid = 2'b00;
    if (q.size() >= 1 && !st && !fl)
      e_valid[0] = 1'b1;
    if (e_valid[0] && q.size() >= 2 && !pair_blocked(q[0].inst, q[1].inst))
      e_valid[1] = 1'b1;
    @(negedge clk);
  endtask

  task automatic advance();
    int npop;
    npop = int'(e_valid[0]) + int'(e_valid[1]);
    if (c_fl) begin
      q.delete();
    end else begin
      repeat (npop) void'(q.pop_front());
      if (e_ready && c_iv[0]) begin
        q.push_back('{c_i0, c_pc});
        if (c_iv[1]) q.push_back('{c_i1, c_pc + PC_W'(4)});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    apply(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, '0);
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #2;
    if (fif.count !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fif.count); end
    checks++;
    if (fif.in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", fif.in_ready); end
    checks++;
    if (fif.out_valid !== 2'b00) begin failures++; $display("FAIL reset_valid got=%b exp=00", fif.out_valid); end
    checks++;
    if (fif.out_inst0 !== 32'd0 || fif.out_pc1 !== '0) begin
      failures++; $display("FAIL reset_data got=%h/%h exp=0/0", fif.out_inst0, fif.out_pc1);
    end
    checks++;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_pair_issue();
    apply(1'b0, 1'b0, 2'b11, 32'h00500093, 32'h00100113, 8'h10);
    advance();
    idle();
    if (fif.out_valid !== 2'b11) begin failures++; $display("FAIL pair_valid got=%b exp=11", fif.out_valid); end
    checks++;
    if (fif.out_pc0 !== 8'h10 || fif.out_pc1 !== 8'h14) begin
      failures++; $display("FAIL pair_pc got=%h/%h exp=10/14", fif.out_pc0, fif.out_pc1);
    end
    checks++;
    if (fif.count !== CW'(2) || fif.out_inst1 !== 32'h00100113) begin
      failures++; $display("FAIL pair_count got=%0d/%h exp=2/00100113", fif.count, fif.out_inst1);
    end
    checks++;
    advance();
    idle();
    if (fif.count !== '0) begin failures++; $display("FAIL pair_drain got=%0d exp=0", fif.count); end
    checks++;
    advance();
  endtask

  task automatic test_raw();
    apply(1'b0, 1'b0, 2'b11, 32'h00500093, 32'h00108133, 8'h20);
    advance();
    idle();
    if (fif.out_valid !== 2'b01 || fif.out_pc0 !== 8'h20) begin
      failures++; $display("FAIL raw_first got=%b/%h exp=01/20", fif.out_valid, fif.out_pc0);
    end
    checks++;
    advance();
    idle();
    if (fif.out_valid !== 2'b01 || fif.out_pc0 !== 8'h24 || fif.out_inst0 !== 32'h00108133) begin
      failures++; $display("FAIL raw_second got=%b/%h/%h exp=01/24/00108133",
                           fif.out_valid, fif.out_pc0, fif.out_inst0);
    end
    checks++;
    advance();
  endtask

  task automatic test_fill_wrap();
    for (int k = 0; k < DEPTH / 2 + 2; k++) begin
      apply(1'b0, 1'b1, 2'b11, mk_addi(2 * k + 1), mk_addi(2 * k + 2), PC_W'(8'h80 + 8 * k));
      if (fif.count !== e_count || fif.in_ready !== e_ready) begin
        failures++; $display("FAIL fill_step%0d got=%0d/%b exp=%0d/%b", k, fif.count, fif.in_ready, e_count, e_ready);
      end
      checks++;
      advance();
    end
    apply(1'b0, 1'b1, 2'b00, 32'd0, 32'd0, '0);
    if (fif.count !== CW'(DEPTH) || fif.in_ready !== 1'b0) begin
      failures++; $display("FAIL fill_full got=%0d/%b exp=%0d/0", fif.count, fif.in_ready, DEPTH);
    end
    checks++;
    advance();
    for (int k = 0; k < DEPTH; k++) begin
      idle();
      if (fif.out_valid !== e_valid) begin
        failures++; $display("FAIL drain_valid%0d got=%b exp=%b", k, fif.out_valid, e_valid);
      end
      checks++;
      if (e_valid[0] && (fif.out_inst0 !== q[0].inst || fif.out_pc0 !== q[0].pc)) begin
        failures++; $display("FAIL drain_slot0_%0d got=%h/%h exp=%h/%h", k, fif.out_inst0, fif.out_pc0, q[0].inst, q[0].pc);
      end
      if (e_valid[0]) checks++;
      if (e_valid[1] && (fif.out_inst1 !== q[1].inst || fif.out_pc1 !== q[1].pc)) begin
        failures++; $display("FAIL drain_slot1_%0d got=%h/%h exp=%h/%h", k, fif.out_inst1, fif.out_pc1, q[1].inst, q[1].pc);
      end
      if (e_valid[1]) checks++;
      advance();
    end
    idle();
    if (fif.count !== '0) begin failures++; $display("FAIL drain_empty got=%0d exp=0", fif.count); end
    checks++;
    advance();
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 1'b1, 2'b11, mk_addi(k), mk_addi(k + 10), PC_W'(8 * k));
      advance();
    end
    apply(1'b1, 1'b0, 2'b11, 32'h00500093, 32'h00100113, 8'h60);
    if (fif.out_valid !== 2'b00 || fif.count !== CW'(6)) begin
      failures++; $display("FAIL flush_cycle got=%b/%0d exp=00/6", fif.out_valid, fif.count);
    end
    checks++;
    advance();
    idle();
    if (fif.count !== '0 || fif.in_ready !== 1'b1 || fif.out_valid !== 2'b00) begin
      failures++; $display("FAIL flush_after got=%0d/%b/%b exp=0/1/00", fif.count, fif.in_ready, fif.out_valid);
    end
    checks++;
    advance();
  endtask

  task automatic test_ctrl_mem();
    logic [31:0] a [2];
    logic [31:0] b [2];
    a = '{32'h00208463, 32'h00112023};
    b = '{32'h00100113, 32'h00012183};
    for (int p = 0; p < 2; p++) begin
      apply(1'b0, 1'b0, 2'b11, a[p], b[p], 8'h70);
      advance();
      idle();
      if (fif.out_valid !== 2'b01 || fif.out_inst0 !== a[p]) begin
        failures++; $display("FAIL single_first%0d got=%b/%h exp=01/%h", p, fif.out_valid, fif.out_inst0, a[p]);
      end
      checks++;
      advance();
      idle();
      if (fif.out_valid !== 2'b01 || fif.out_inst0 !== b[p] || fif.out_pc0 !== 8'h74) begin
        failures++; $display("FAIL single_second%0d got=%b/%h/%h exp=01/%h/74",
                             p, fif.out_valid, fif.out_inst0, fif.out_pc0, b[p]);
      end
      checks++;
      advance();
    end
  endtask

  task automatic test_reset_mid();
    apply(1'b0, 1'b1, 2'b11, mk_addi(1), mk_addi(2), 8'h50); advance();
    apply(1'b0, 1'b1, 2'b11, mk_addi(3), mk_addi(4), 8'h58); advance();
    apply(1'b0, 1'b1, 2'b01, mk_addi(5), mk_addi(6), 8'h5c); advance();
    apply(1'b0, 1'b1, 2'b00, 32'd0, 32'd0, '0);
    if (fif.count !== CW'(5)) begin failures++; $display("FAIL mid_prefill got=%0d exp=5", fif.count); end
    checks++;
    reset = 1'b0;
    #1;
    if (fif.count !== '0 || fif.out_valid !== 2'b00 || fif.in_ready !== 1'b1 ||
        fif.out_inst0 !== 32'd0 || fif.out_pc0 !== '0) begin
      failures++; $display("FAIL mid_reset got=%0d/%b/%b/%h/%h exp=0/00/1/0/0",
                           fif.count, fif.out_valid, fif.in_ready, fif.out_inst0, fif.out_pc0);
    end
    checks++;
    q.delete();
    fif.stall = 1'b0;
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    apply(1'b0, 1'b0, 2'b01, 32'h00500093, 32'd0, 8'h40);
    advance();
    idle();
    if (fif.out_valid !== 2'b01 || fif.out_pc0 !== 8'h40 || fif.count !== CW'(1)) begin
      failures++; $display("FAIL mid_repush got=%b/%h/%0d exp=01/40/1", fif.out_valid, fif.out_pc0, fif.count);
    end
    checks++;
    advance();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      apply(($urandom % 16) == 0, ($urandom % 4) == 0, 2'($urandom), rand_inst(), rand_inst(), PC_W'($urandom));
      if (fif.out_valid !== e_valid) begin
        failures++; $display("FAIL rand_valid%0d got=%b exp=%b", n, fif.out_valid, e_valid);
      end
      checks++;
      if (fif.count !== e_count || fif.in_ready !== e_ready) begin
        failures++; $display("FAIL rand_count%0d got=%0d/%b exp=%0d/%b", n, fif.count, fif.in_ready, e_count, e_ready);
      end
      checks++;
      if (e_valid[0] && (fif.out_inst0 !== q[0].inst || fif.out_pc0 !== q[0].pc)) begin
        failures++; $display("FAIL rand_slot0_%0d got=%h/%h exp=%h/%h", n, fif.out_inst0, fif.out_pc0, q[0].inst, q[0].pc);
      end
      if (e_valid[0]) checks++;
      if (e_valid[1] && (fif.out_inst1 !== q[1].inst || fif.out_pc1 !== q[1].pc)) begin
        failures++; $display("FAIL rand_slot1_%0d got=%h/%h exp=%h/%h", n, fif.out_inst1, fif.out_pc1, q[1].inst, q[1].pc);
      end
      if (e_valid[1]) checks++;
      advance();
    end
  endtask

  initial begin
    fif.flush = 1'b0; fif.stall = 1'b0; fif.in_valid = 2'b00;
    fif.in_inst0 = '0; fif.in_inst1 = '0; fif.in_pc = '0;
    test_reset();
    test_pair_issue();
    test_raw();
    test_fill_wrap();
    test_flush();
    test_ctrl_mem();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before test sequence completed");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fetch_issue_queue.md
FETCH_ISSUE_QUEUE -- requirements
Module: fetch_issue_queue

Interface
REQ-001 The module SHALL have parameter DEPTH, 8, queue entries; power of two, minimum 4.
REQ-002 The module SHALL have parameter PC_W, 8, width of stored program-counter tags.
REQ-003 The module SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The module SHALL have port flush  input  1  synchronous queue discard on branch rollback.
REQ-006 The module SHALL have port stall  input  1  downstream load-use stall; blocks all issue.
REQ-007 The module SHALL have port in_valid  input  2  fetch slot valids; bit0 = in_inst0, bit1 = in_inst1.
REQ-008 The module SHALL have port in_inst0 / in_inst1  input  32 each  fetched instructions in program order.
REQ-009 The module SHALL have port in_pc  input  PC_W  PC of in_inst0; in_inst1 tagged in_pc+4 (mod 2^PC_W).
REQ-010 The module SHALL have port in_ready  output  1  high when at least 2 entries free.
REQ-011 The module SHALL have port out_valid  output  2  issue this cycle; bit0 = slot0, bit1 = slot1.
REQ-012 The module SHALL have port out_inst0 / out_inst1  output  32 each  head and head+1 instructions.
REQ-013 The module SHALL have port out_pc0 / out_pc1  output  PC_W each  tags of issued instructions.
REQ-014 The module SHALL have port count  output  log2(DEPTH)+1  registered occupancy.

Function
REQ-015 Storage SHALL be a circular buffer with registered head, tail and count; pointers wrap modulo DEPTH.
REQ-016 Enqueue SHALL occur only when in_ready is high; in_ready SHALL be computed from registered count alone (no credit for same-cycle dequeue).
REQ-017 in_valid=01 SHALL enqueue in_inst0 only; 11 SHALL enqueue both, in_inst0 first; 10 SHALL be ignored (nothing written).
REQ-018 Enqueued entries SHALL first be visible on out_* the cycle after the write edge; no input-to-output bypass.
REQ-019 out_valid[0] SHALL be high iff count>=1, stall=0, flush=0.
REQ-020 out_valid[1] SHALL be high iff out_valid[0], count>=2, and no pairing hazard (REQ-021..023).
REQ-021 RAW hazard: slot0 writes rd (opcode 0110011, 0010011, 0000011, 1101111, 1100111, 0110111, 0010111), rd!=0, and slot1 reads that rd as rs1 (opcodes other than 0110111, 0010111, 1101111) or rs2 (opcodes 0110011, 0100011, 1100011).
REQ-022 Control hazard: slot0 opcode is 1100011, 1101111 or 1100111 -> slot1 withheld.
REQ-023 Memory hazard: both slot0 and slot1 are loads/stores (0000011 or 0100011) -> slot1 withheld.
REQ-024 Field extraction SHALL use rd=[11:7], rs1=[19:15], rs2=[24:20], opcode=[6:0].
REQ-025 Dequeue SHALL advance head by popcount(out_valid) at the clock edge; withheld instruction remains at head.
REQ-026 Simultaneous enqueue and dequeue SHALL update count = count + pushed - popped.
REQ-027 flush SHALL take priority: next state count=0, head=tail; same-cycle inputs dropped; out_valid=00 that cycle.
REQ-028 out_inst*/out_pc* SHALL show head contents whenever count covers the slot, else zero; they are don't-care when the matching out_valid is low.
REQ-029 count SHALL never exceed DEPTH nor underflow; in_valid while in_ready=0 SHALL be ignored.

Reset
REQ-030 While reset=0: head=tail=0, count=0, in_ready=1, out_valid=00, out_inst*=0, out_pc*=0, asynchronously.
REQ-031 Reset asserted mid-operation SHALL discard all entries; first enqueue is accepted on the first edge after reset=1.

Verification
REQ-032 Push 0x00500093 (addi x1,x0,5) / 0x00100113 (addi x2,x0,1), in_pc=0x10 -> next cycle out_valid=11, out_pc0=0x10, out_pc1=0x14, count 2->0.
REQ-033 Push 0x00500093 / 0x00108133 (add x2,x1,x1) -> out_valid=01 first cycle, then 01 for add, out_pc0=in_pc+4.
REQ-034 Push pairs every cycle, stall=1 -> count reaches DEPTH after DEPTH/2 edges, in_ready=0, extra pushes dropped; release stall -> order preserved across pointer wrap.
REQ-035 Queue holding 6 entries, flush=1 with in_valid=11 -> next cycle count=0, out_valid=00, in_ready=1.
REQ-036 Push 0x00208463 (beq) / 0x00100113 -> out_valid=01 then 01; sw/lw pair -> issued singly.
REQ-037 Drop reset to 0 with count=5 mid-run -> outputs zero immediately; push after release appears one cycle later with correct PC.
